audio_freq_divider: RTL

AUDIO_FREQ_DIVIDER -- requirements
Module: audio_freq_divider

---
 rtl/audio_freq_divider_if.sv | 21 ++
 rtl/audio_freq_divider.sv | 94 +++++++++
 2 files changed

// File: rtl/audio_freq_divider_if.sv
// Register-write bus and tick/level outputs of the audio frequency divider.
// The master side writes the registers; the slave side is the divider itself.
interface audio_freq_divider_if;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [4:0] wr_data;
   logic [3:0] audc;
   logic [3:0] audv;
   logic       audio_tick;
   logic       shift_tick;

   modport master (
      output wr_en, wr_addr, wr_data,
      input  audc, audv, audio_tick, shift_tick
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      output audc, audv, audio_tick, shift_tick
   );
endinterface

// File: rtl/audio_freq_divider.sv
// Audio channel frequency divider: /114 prescaler, AUDF divider, AUDC clock modifier
// (/3, /31 or pass-through) and registered shift pulse for the noise/tone shifter.
module audio_freq_divider (
   input  logic                 clk,
   input  logic                 rst_n,
   audio_freq_divider_if.slave  bus
);

   localparam logic [6:0] PRE_LAST = 7'd113;

   logic [6:0] pre_cnt;
   logic [4:0] div_cnt;
   logic [4:0] mod_cnt;
   logic [3:0] audc_reg;
   logic [4:0] audf_reg;
   logic [3:0] audv_reg;
   logic       shift_tick_r;

   logic       audio_tick;
   logic       freq_tick;
   logic       mode_div3;
   logic       mode_div31;
   logic       mod_pass;
   logic       audc_wr;

   assign audio_tick = (pre_cnt == PRE_LAST);
   assign freq_tick  = audio_tick && (div_cnt >= audf_reg);
   assign mode_div3  = (audc_reg[3:2] == 2'b11);
   assign mode_div31 = (audc_reg == 4'd6) || (audc_reg == 4'd10);
   assign audc_wr    = bus.wr_en && (bus.wr_addr == 2'd0);

   always_comb begin
      mod_pass = 1'b1;
      if (mode_div3)
         mod_pass = (mod_cnt == 5'd2);
      else if (mode_div31)
         mod_pass = (mod_cnt == 5'd30);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         div_cnt <= '0;
      end else begin
         pre_cnt <= audio_tick ? 7'd0 : pre_cnt + 7'd1;
         // A lowered AUDF leaves div_cnt above it; the >= compare wraps it on the next tick.
         if (audio_tick)
            div_cnt <= (div_cnt >= audf_reg) ? 5'd0 : div_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_cnt <= '0;
      end else if (audc_wr) begin
         mod_cnt <= '0;
      end else if (freq_tick) begin
         if (mode_div3)
            mod_cnt <= (mod_cnt >= 5'd2) ? 5'd0 : mod_cnt + 5'd1;
         else if (mode_div31)
            mod_cnt <= (mod_cnt >= 5'd30) ? 5'd0 : mod_cnt + 5'd1;
         else
            mod_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         audc_reg <= '0;
         audf_reg <= '0;
         audv_reg <= '0;
      end else if (bus.wr_en) begin
         case (bus.wr_addr)
            2'd0:    audc_reg <= bus.wr_data[3:0];
            2'd1:    audf_reg <= bus.wr_data;
            2'd2:    audv_reg <= bus.wr_data[3:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shift_tick_r <= 1'b0;
      else
         shift_tick_r <= freq_tick && mod_pass && (audc_reg != 4'd0);
   end

   assign bus.audio_tick = audio_tick;
   assign bus.shift_tick = shift_tick_r;
   assign bus.audc       = audc_reg;
   assign bus.audv       = audv_reg;

endmodule
